mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multiplier core among four requesters. It accepts operand pairs from the requesters and drives the core's clear/start controls. It waits for the core's `op_done`, then returns the 128-bit product to the owning requester with a one-cycle done pulse. A watchdog aborts hung operations. It sits between client blocks and the multiplier top level.

---
 rtl/mul_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mul_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//
// Round-robin arbiter and sequencer that shares one multiplier core among four
// requesters. It captures the winning requester's operand pair, steps the core
// through clear and start, then waits for the core's done flag. When the flag
// arrives it returns the product to the owner with a one-cycle done pulse. A
// watchdog aborts an operation that stays in WAIT for TIMEOUT cycles; the abort
// returns a zero product with err.
//
// Parameters:
//   WIDTH    operand width; the product is 2*WIDTH bits
//   TIMEOUT  maximum number of WAIT cycles before abort (>= 2)
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   req[3:0]       per-requester request, held until the matching gnt bit
//   req_a/req_b    operand pairs, requester i in bits [i*WIDTH +: WIDTH]
//   gnt[3:0]       one-hot pulse: the owner's operands were captured
//   done[3:0]      one-hot pulse: result is valid for the owner
//   result         product, held until the next done
//   err            pulse coincident with done when the watchdog aborted
//   busy           high whenever the sequencer is not IDLE
//   m_clear        clear strobe to the core (CLEAR state)
//   m_start        start strobe to the core (START state)
//   m_multiplicand registered operand a to the core
//   m_multiplier   registered operand b to the core
//   m_op_done      core done level
//   m_result       core product
// -----------------------------------------------------------------------------
module mul_arbiter #(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   req_a,
    input  logic [4*WIDTH-1:0]   req_b,
    output logic [3:0]           gnt,
    output logic [3:0]           done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic                 m_clear,
    output logic                 m_start,
    output logic [WIDTH-1:0]     m_multiplicand,
    output logic [WIDTH-1:0]     m_multiplier,
    input  logic                 m_op_done,
    input  logic [2*WIDTH-1:0]   m_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT-1, which fits in clog2(TIMEOUT) bits.
    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           gnt_q, gnt_d;
    logic [3:0]           done_q, done_d;
    logic                 err_q, err_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;

    // Round-robin pick: first set bit scanning upward from last_q+1 with wrap.
    logic                 pick_valid;
    logic [1:0]           pick_idx;
    logic [1:0]           scan_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_q;
        scan_idx   = last_q;
        // Scan from the farthest offset down so the nearest set bit is written last.
        for (int k = 4; k >= 1; k--) begin
            scan_idx = last_q + 2'(k);
            if (req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which is what would infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = 4'b0000;
        done_d   = 4'b0000;
        err_d    = 1'b0;
        result_d = result_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    op_a_d  = req_a[int'(pick_idx)*WIDTH +: WIDTH];
                    op_b_d  = req_b[int'(pick_idx)*WIDTH +: WIDTH];
                    gnt_d   = 4'b0001 << pick_idx;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // The core's done flag takes priority over a coincident timeout.
                if (m_op_done) begin
                    result_d = m_result;
                    done_d   = 4'b0001 << owner_q;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    done_d   = 4'b0001 << owner_q;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= '0;
            gnt_q    <= 4'b0000;
            done_q   <= 4'b0000;
            err_q    <= 1'b0;
            result_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign err            = err_q;
    assign result         = result_q;
    assign m_multiplicand = op_a_q;
    assign m_multiplier   = op_b_q;
    assign m_clear        = (state_q == CLEAR);
    assign m_start        = (state_q == START);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter
//
// Self-checking bench for mul_arbiter. A transaction-level reference model
// predicts the round-robin owner, the captured operands, and the cycle on which
// done appears. It also predicts whether that done carries a product or a
// watchdog abort. The bench plays the multiplier core: it raises m_op_done a
// chosen number of WAIT cycles after start and drives the full unsigned product.
// -----------------------------------------------------------------------------
module tb_mul_arbiter;

    localparam int W  = 64;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [4*W-1:0]   req_a;
    logic [4*W-1:0]   req_b;
    logic [3:0]       gnt;
    logic [3:0]       done;
    logic [2*W-1:0]   result;
    logic             err;
    logic             busy;
    logic             m_clear;
    logic             m_start;
    logic [W-1:0]     m_multiplicand;
    logic [W-1:0]     m_multiplier;
    logic             m_op_done;
    logic [2*W-1:0]   m_result;

    mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_a          (req_a),
        .req_b          (req_b),
        .gnt            (gnt),
        .done           (done),
        .result         (result),
        .err            (err),
        .busy           (busy),
        .m_clear        (m_clear),
        .m_start        (m_start),
        .m_multiplicand (m_multiplicand),
        .m_multiplier   (m_multiplier),
        .m_op_done      (m_op_done),
        .m_result       (m_result)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int           model_last  = 3;
    logic [2*W-1:0] last_result = '0;

    // First requester with a set bit, scanning upward from last+1 with wrap.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = 4'b0000;
        m_op_done = 1'b0;
        m_result  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        model_last  = 3;
        last_result = '0;
    endtask

    // One full transaction. Drives r (state must be IDLE in the current cycle),
    // expects gnt on the next cycle, then plays the core with done after d WAIT
    // cycles (d >= TO means the core never answers).
    task automatic do_txn(input logic [3:0] r, input bit hold, input int d);
        int             own;
        int             wd;
        bit             eerr;
        logic [W-1:0]   ea;
        logic [W-1:0]   eb;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] eres;

        own        = rr_pick(r, model_last);
        model_last = own;
        ea         = req_a[own*W +: W];
        eb         = req_b[own*W +: W];
        prod       = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
        eerr       = (d > TO - 1);
        wd         = (eerr ? TO - 1 : d) + 1;
        eres       = eerr ? '0 : prod;

        req = r;
        @(posedge clk);
        #1;
        checks++;
        if ({gnt, m_clear, m_start, busy, done, err} !== {4'(1 << own), 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL grant: got gnt=%b clr=%b st=%b busy=%b done=%b err=%b, want gnt=%b clr=1 st=0 busy=1 done=0000 err=0",
                     gnt, m_clear, m_start, busy, done, err, 4'(1 << own));
        end
        checks++;
        if (result !== last_result) begin
            errors++;
            $display("FAIL result_hold: got %h want %h", result, last_result);
        end
        if (!hold) req[own] = 1'b0;

        @(posedge clk);
        #1;
        checks++;
        if ({gnt, m_clear, m_start, busy} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL start: got gnt=%b clr=%b st=%b busy=%b, want 0000 0 1 1", gnt, m_clear, m_start, busy);
        end
        checks++;
        if ({m_multiplicand, m_multiplier} !== {ea, eb}) begin
            errors++;
            $display("FAIL operands: got a=%h b=%h want a=%h b=%h", m_multiplicand, m_multiplier, ea, eb);
        end

        m_result = prod;
        for (int w = 0; w <= TO + 1; w++) begin
            @(posedge clk);
            #1;
            if (w == wd) begin
                checks++;
                if ({done, err, busy, m_clear, m_start} !== {4'(1 << own), eerr, 1'b0, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL done: got done=%b err=%b busy=%b clr=%b st=%b, want done=%b err=%b busy=0",
                             done, err, busy, m_clear, m_start, 4'(1 << own), eerr);
                end
                checks++;
                if (result !== eres) begin
                    errors++;
                    $display("FAIL result: got %h want %h", result, eres);
                end
                last_result = eres;
                m_op_done   = 1'b0;
                break;
            end
            checks++;
            if ({done, err, busy, m_clear, m_start} !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL wait: cycle %0d got done=%b err=%b busy=%b clr=%b st=%b, want 0000 0 1 0 0",
                         w, done, err, busy, m_clear, m_start);
            end
            m_op_done = (w >= d);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, done, err, busy, m_clear, m_start} !== 12'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b busy=%b clr=%b st=%b, want all 0",
                     gnt, done, err, busy, m_clear, m_start);
        end
        checks++;
        if ({result, m_multiplicand, m_multiplier} !== '0) begin
            errors++;
            $display("FAIL reset_data: got result=%h a=%h b=%h, want 0", result, m_multiplicand, m_multiplier);
        end
    endtask

    task automatic test_idle();
        req = 4'b0000;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({gnt, busy, m_clear, m_start, done} !== 11'b0) begin
                errors++;
                $display("FAIL idle: got gnt=%b busy=%b clr=%b st=%b done=%b, want all 0",
                         gnt, busy, m_clear, m_start, done);
            end
        end
    endtask

    task automatic test_single();
        set_ops(0, 64'd3, 64'd5);
        do_txn(4'b0001, 1'b0, 2);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 64'(i + 1), 64'd2);
        for (int n = 0; n < 5; n++) do_txn(4'b1111, 1'b1, n % TO);
        req = 4'b0000;
    endtask

    task automatic test_max_operands();
        set_ops(1, {W{1'b1}}, {W{1'b1}});
        do_txn(4'b0010, 1'b0, 1);
    endtask

    task automatic test_timeout();
        set_ops(2, 64'd7, 64'd9);
        set_ops(3, 64'd11, 64'd13);
        do_txn(4'b0100, 1'b0, 1000);
        // The following requester must be served next, starting with a clear.
        do_txn(4'b1100, 1'b0, 0);
        req = 4'b0000;
    endtask

    task automatic test_done_and_timeout();
        set_ops(0, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321);
        do_txn(4'b0001, 1'b0, TO - 1);
    endtask

    task automatic test_reset_in_wait();
        set_ops(3, 64'd21, 64'd2);
        set_ops(2, 64'd6, 64'd7);
        req = 4'b1000;
        repeat (4) @(posedge clk);   // gnt, START, WAIT 0, WAIT 1
        #1;
        req   = 4'b0000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({gnt, done, err, busy, m_clear, m_start} !== 12'b0) begin
            errors++;
            $display("FAIL reset_wait_ctrl: got gnt=%b done=%b err=%b busy=%b clr=%b st=%b, want all 0",
                     gnt, done, err, busy, m_clear, m_start);
        end
        checks++;
        if ({result, m_multiplicand, m_multiplier} !== '0) begin
            errors++;
            $display("FAIL reset_wait_data: got result=%h a=%h b=%h, want 0", result, m_multiplicand, m_multiplier);
        end
        model_last  = 3;
        last_result = '0;
        do_txn(4'b0100, 1'b0, 1);
    endtask

    task automatic test_random();
        logic [3:0] r;
        req = 4'b0000;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) set_ops(i, {$urandom, $urandom}, {$urandom, $urandom});
            // Ungranted requesters keep their request asserted.
            r = req | 4'($urandom_range(1, 15));
            do_txn(r, 1'b0, int'($urandom_range(0, TO + 1)));
        end
        req = 4'b0000;
    endtask

    initial begin
        reset     = 1'b1;
        req       = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        m_op_done = 1'b0;
        m_result  = '0;

        test_reset();
        test_idle();
        test_single();
        test_max_operands();
        test_done_and_timeout();
        test_timeout();
        test_round_robin();
        test_reset_in_wait();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
